// File: rtl/johnson_pattern_rx.sv
// -----------------------------------------------------------------------------
// johnson_pattern_rx
//
// Receive side of the 8-state Johnson LED pattern generator. The block
// synchronises the asynchronous 4-bit pattern bus and ignores glitches. It
// decodes each accepted code to a 3-bit position. It also checks that
// successive positions step by exactly +1 or -1 (mod 8).
//
// Parameters
//   STABLE_CYC : synchronised cycles a new code must hold before it is
//                accepted (1..255)
//   ERR_W      : width of the saturating error counter
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous reset, active-low
//   pat_in    in   {led4,led3,led2,led1}, asynchronous to clk
//   pos       out  last accepted position 0..7
//   pos_valid out  one-cycle pulse when a new position is accepted
//   dir       out  1 = last legal step was +1, 0 = last legal step was -1
//   locked    out  high while stepping is being verified
//   code_err  out  one-cycle pulse when a non-Johnson code is accepted
//   step_err  out  one-cycle pulse when a legal code skips or jumps
//   err_cnt   out  saturating count of code_err + step_err events
// -----------------------------------------------------------------------------
module johnson_pattern_rx #(
  parameter int STABLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       pat_in,
  output logic [2:0]       pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             locked,
  output logic             code_err,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // Returns {legal, position}.
  function automatic logic [3:0] decode(input logic [3:0] code);
    logic [3:0] r;
    case (code)
      4'b0000: r = 4'b1_000;
      4'b0001: r = 4'b1_001;
      4'b0011: r = 4'b1_010;
      4'b0111: r = 4'b1_011;
      4'b1111: r = 4'b1_100;
      4'b1110: r = 4'b1_101;
      4'b1100: r = 4'b1_110;
      4'b1000: r = 4'b1_111;
      default: r = 4'b0_000;
    endcase
    return r;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  // Synchroniser and filter state
  logic [3:0] sync1_q, sync2_q, prev_q, last_q;
  logic       sv1_q, sv2_q, pv_q, last_vld_q;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;

  // Decoder / FSM state
  state_e           state_q;
  logic [2:0]       pos_q;
  logic             pos_valid_q, dir_q, code_err_q, step_err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [3:0] dec;
  logic       legal;
  logic [2:0] new_pos;
  logic [2:0] step;

  // sv1_q/sv2_q track that the synchroniser stages hold real samples
  // taken since reset. The reset contents of the flops are therefore
  // never treated as a received code. The first real sync2 value then
  // counts as a fresh change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      sv1_q      <= 1'b0;
      sv2_q      <= 1'b0;
      prev_q     <= 4'b0000;
      pv_q       <= 1'b0;
      cnt_q      <= 8'd0;
      last_q     <= 4'b0000;
      last_vld_q <= 1'b0;
    end else begin
      sync1_q <= pat_in;
      sync2_q <= sync1_q;
      sv1_q   <= 1'b1;
      sv2_q   <= sv1_q;
      prev_q  <= sync2_q;
      pv_q    <= sv2_q;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_q     <= sync2_q;
        last_vld_q <= 1'b1;
      end
    end
  end

  // Stability counter: restarts at 1 on any change, saturates at STABLE_CYC.
  always_comb begin
    cnt_d = 8'd0;
    if (sv2_q) begin
      if (!pv_q || (sync2_q != prev_q)) begin
        cnt_d = 8'd1;
      end else if (cnt_q < STABLE_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Comparing against the last accepted code makes a held value fire once.
  assign accept  = (cnt_d == STABLE_MAX) && (!last_vld_q || (sync2_q != last_q));

  assign dec     = decode(sync2_q);
  assign legal   = dec[3];
  assign new_pos = dec[2:0];
  assign step    = new_pos - pos_q;   // modulo-8 difference via 3-bit wrap

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      pos_q       <= 3'd0;
      pos_valid_q <= 1'b0;
      dir_q       <= 1'b1;
      code_err_q  <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pos_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      step_err_q  <= 1'b0;
      if (accept) begin
        if (!legal) begin
          code_err_q <= 1'b1;
          err_cnt_q  <= sat_inc(err_cnt_q);
          state_q    <= UNLOCKED;
        end else begin
          pos_q       <= new_pos;
          pos_valid_q <= 1'b1;
          state_q     <= LOCKED;
          // The first code after unlock only establishes the reference.
          if (state_q == LOCKED) begin
            if (step == 3'd1) begin
              dir_q <= 1'b1;
            end else if (step == 3'd7) begin
              dir_q <= 1'b0;
            end else begin
              step_err_q <= 1'b1;
              err_cnt_q  <= sat_inc(err_cnt_q);
            end
          end
        end
      end
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign dir       = dir_q;
  assign locked    = (state_q == LOCKED);
  assign code_err  = code_err_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
